ifetch_unit: RTL and testbench

Instruction-fetch stage of the pipeline. It owns the PC, issues one instruction-bus request at a time, and buffers the returned word while the pipeline is stalled. It discards responses made stale by a control-flow redirect. It sits directly upstream of the hazard unit and the F/D pipeline register: it produces `i_data_ok` for the hazard unit and consumes the hazard unit's `stallF`.

---
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one bus request in flight, holds the
// returned word while fetch is stalled and discards responses made stale by a redirect.
module ifetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        i_data_ok,
  output logic [63:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      state_r;
  logic [63:0] pc_r;
  logic        drop_r;
  logic [31:0] buf_r;
  logic [63:0] target_s;

  assign target_s = redirect_pc & ~64'h3;

  // Presented instruction and bus request; i_data_ok never looks at stallF.
  always_comb begin
    ireq_valid  = 1'b0;
    i_data_ok   = 1'b0;
    fetch_instr = 32'h0;
    ireq_addr   = pc_r;
    fetch_pc    = pc_r;
    case (state_r)
      ST_REQ: begin
        ireq_valid = 1'b1;
      end
      ST_WAIT: begin
        if (iresp_data_ok && !drop_r && !redirect_valid) begin
          i_data_ok   = 1'b1;
          fetch_instr = iresp_data;
        end else begin
          i_data_ok   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!redirect_valid) begin
          i_data_ok   = 1'b1;
          fetch_instr = buf_r;
        end else begin
          i_data_ok   = 1'b0;
        end
      end
      default: begin
        ireq_valid = 1'b0;
      end
    endcase
  end

  // Fetch state machine, PC, drop flag and stall buffer; redirect wins every transition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      drop_r  <= 1'b0;
      buf_r   <= 32'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (redirect_valid) begin
            pc_r <= target_s;
          end
          state_r <= ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            pc_r <= target_s;
            if (ireq_addr_ok) begin
              state_r <= ST_WAIT;
              drop_r  <= 1'b1;
            end
          end else if (ireq_addr_ok) begin
            state_r <= ST_WAIT;
            drop_r  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            pc_r <= target_s;
            if (iresp_data_ok) begin
              state_r <= ST_REQ;
              drop_r  <= 1'b0;
            end else begin
              drop_r  <= 1'b1;
            end
          end else if (iresp_data_ok) begin
            if (drop_r) begin
              drop_r  <= 1'b0;
              state_r <= ST_REQ;
            end else if (!stallF) begin
              pc_r    <= pc_r + 64'd4;
              state_r <= ST_REQ;
            end else begin
              buf_r   <= iresp_data;
              state_r <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redirect_valid) begin
            pc_r    <= target_s;
            state_r <= ST_REQ;
          end else if (!stallF) begin
            pc_r    <= pc_r + 64'd4;
            state_r <= ST_REQ;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed cycle-by-cycle bench for ifetch_unit with hand-computed expectations.
module tb_ifetch_unit;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stallF;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        i_data_ok;
  logic [63:0] fetch_pc;
  logic [31:0] fetch_instr;

  int n_compared;
  int n_mismatched;

  ifetch_unit #(.RESET_PC(64'h8000_0000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_addr_ok  (ireq_addr_ok),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .i_data_ok     (i_data_ok),
    .fetch_pc      (fetch_pc),
    .fetch_instr   (fetch_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aok, input logic dok, input logic [31:0] d,
                       input logic stl, input logic rv, input logic [63:0] rpc);
    ireq_addr_ok   = aok;
    iresp_data_ok  = dok;
    iresp_data     = d;
    stallF         = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    repeat (3) next_cycle();
    #1;
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_i_data_ok", 64'(i_data_ok), 64'd0);
    check("rst_ireq_addr", ireq_addr, 64'h8000_0000);
    check("rst_fetch_pc", fetch_pc, 64'h8000_0000);
    check("rst_fetch_instr", 64'(fetch_instr), 64'd0);

    // Release: IDLE this cycle, REQ after the next edge.
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("idle_ireq_valid", 64'(ireq_valid), 64'd0);

    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("first_req_valid", 64'(ireq_valid), 64'd1);
    check("first_req_addr", ireq_addr, 64'h8000_0000);

    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'h0);
    check("first_data_ok", 64'(i_data_ok), 64'd1);
    check("first_fetch_pc", fetch_pc, 64'h8000_0000);
    check("first_fetch_instr", 64'(fetch_instr), 64'h13);
    check("wait_no_req", 64'(ireq_valid), 64'd0);

    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("second_req_valid", 64'(ireq_valid), 64'd1);
    check("second_req_addr", ireq_addr, 64'h8000_0004);

    // Stall hold: response with stallF high for three cycles.
    next_cycle();
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 64'h0);
    check("stall0_data_ok", 64'(i_data_ok), 64'd1);
    check("stall0_instr", 64'(fetch_instr), 64'hDEAD_BEEF);
    for (int i = 1; i < 3; i++) begin
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      check("hold_data_ok", 64'(i_data_ok), 64'd1);
      check("hold_instr", 64'(fetch_instr), 64'hDEAD_BEEF);
      check("hold_no_req", 64'(ireq_valid), 64'd0);
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("release_data_ok", 64'(i_data_ok), 64'd1);
    check("release_instr", 64'(fetch_instr), 64'hDEAD_BEEF);
    check("release_fetch_pc", fetch_pc, 64'h8000_0004);
    check("release_no_req", 64'(ireq_valid), 64'd0);

    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("after_stall_valid", 64'(ireq_valid), 64'd1);
    check("after_stall_addr", ireq_addr, 64'h8000_0008);

    // Redirect while the request is in flight.
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0100);
    check("redir_wait_data_ok", 64'(i_data_ok), 64'd0);
    next_cycle();
    drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0);
    check("stale_resp_data_ok", 64'(i_data_ok), 64'd0);
    check("stale_resp_no_req", 64'(ireq_valid), 64'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("redir_req_valid", 64'(ireq_valid), 64'd1);
    check("redir_req_addr", ireq_addr, 64'h8000_0100);

    // Redirect coincident with the response.
    next_cycle();
    drive(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 64'h8000_0200);
    check("coinc_data_ok", 64'(i_data_ok), 64'd0);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    check("coinc_req_valid", 64'(ireq_valid), 64'd1);
    check("coinc_req_addr", ireq_addr, 64'h8000_0200);

    // Misaligned redirect while REQ is unaccepted, then wrap-around.
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("misalign_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0033, 1'b0, 1'b0, 64'h0);
    check("wrap_data_ok", 64'(i_data_ok), 64'd1);
    check("wrap_fetch_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("wrap_req_valid", 64'(ireq_valid), 64'd1);
    check("wrap_req_addr", ireq_addr, 64'h0);

    // Reset while the request to 0x0 is outstanding.
    next_cycle();
    resetn = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("midrst_req_valid", 64'(ireq_valid), 64'd0);
    check("midrst_data_ok", 64'(i_data_ok), 64'd0);
    check("midrst_addr", ireq_addr, 64'h8000_0000);
    next_cycle();
    resetn = 1'b1;
    drive(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 64'h0);
    check("idle_stale_data_ok", 64'(i_data_ok), 64'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    check("postrst_req_valid", 64'(ireq_valid), 64'd1);
    check("postrst_req_addr", ireq_addr, 64'h8000_0000);
    check("postrst_data_ok", 64'(i_data_ok), 64'd0);
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0055, 1'b0, 1'b0, 64'h0);
    check("postrst_fetch_ok", 64'(i_data_ok), 64'd1);
    check("postrst_fetch_pc", fetch_pc, 64'h8000_0000);
    check("postrst_fetch_instr", 64'(fetch_instr), 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
